udp_start_seq: RTL and testbench

Parametrised successor to the single-bit UDP start register: a write-port command block that queues per-channel UDP start requests and issues them one at a time over a valid/ready handshake. It tracks which channels are busy until each returns done, and reports FIFO overflow. It sits between the host register-write path and the UDP transmit engines, all in one clock domain.

---
 rtl/udp_start_seq.sv | 138 +++++++++++++
 tb/tb_udp_start_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_start_seq.sv
// Queues per-channel UDP start masks from the host write port and issues them
// one channel at a time over a valid/ready handshake, tracking busy channels.
//
// state   | meaning
// IDLE    | waiting for enable and a queued mask; pops the FIFO head
// ISSUE   | walking cur_mask lowest bit first, one handshake per channel
module udp_start_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter bit EN_RESET   = 1'b1,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   output logic                  start_valid,
   output logic [CH_W-1:0]       start_ch,
   input  logic                  start_ready,
   input  logic [NUM_CH-1:0]     done_i,
   output logic [NUM_CH-1:0]     busy_o,
   output logic [CNT_W-1:0]      fifo_count,
   output logic                  overflow_o
);

   localparam int PTR_W = CNT_W - 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   logic [NUM_CH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [0:0]        state;
   logic [NUM_CH-1:0] cur_mask, busy, ch_onehot, head, mask_left;
   logic              enable, overflow;
   logic              start_wr, ctrl_wr, fifo_full, push, pop, hs;
   logic [CH_W-1:0]   ch_sel;
   logic              unused_wr_data;

   // Only the low bits of wr_data are meaningful; fold the rest away.
   assign unused_wr_data = ^wr_data;

   always_comb begin
      start_wr  = wr_en && (wr_addr == '0);
      ctrl_wr   = wr_en && (wr_addr == ADDR_WIDTH'(1));
      fifo_full = (count == DEPTH_C);
      push      = start_wr && !fifo_full;
      pop       = (state == S_IDLE) && enable && (count != '0);
      head      = fifo_mem[rd_ptr];
   end

   always_comb begin
      ch_sel = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (cur_mask[i]) ch_sel = CH_W'(i);
      end
      ch_onehot   = NUM_CH'(1) << ch_sel;
      mask_left   = cur_mask & ~ch_onehot;
      start_valid = (state == S_ISSUE) && !busy[ch_sel];
      hs          = start_valid && start_ready;
   end

   assign start_ch   = ch_sel;
   assign busy_o     = busy;
   assign fifo_count = count;
   assign overflow_o = overflow;

   always_ff @(posedge aclk) begin
      if (push) fifo_mem[wr_ptr] <= wr_data[NUM_CH-1:0];
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= S_IDLE;
         cur_mask <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  cur_mask <= head;
                  if (head != '0) state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (hs) begin
                  cur_mask <= mask_left;
                  if (mask_left == '0) state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // A handshake and a done on the same channel leave it busy.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~done_i) | (hs ? ch_onehot : '0);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         enable   <= EN_RESET;
         overflow <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            enable <= wr_data[0];
            if (wr_data[1]) overflow <= 1'b0;
         end
         if (start_wr && fifo_full) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_udp_start_seq.sv
// Directed bench for udp_start_seq: queue-based reference model checked every
// cycle, plus literal expectations at the key timing points.
module tb_udp_start_seq;

   localparam int DEPTH = 8;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        wr_en = 1'b0;
   logic        start_ready = 1'b0;
   logic [3:0]  done_i = '0;
   logic        start_valid;
   logic [1:0]  start_ch;
   logic [3:0]  busy_o;
   logic [3:0]  fifo_count;
   logic        overflow_o;

   int checks = 0;
   int errors = 0;
   int dut_hs = 0;
   int hs_base = 0;
   bit chk_en = 1'b0;

   int m_q[$];
   bit m_issuing;
   int m_cur;
   int m_busy;
   bit m_en;
   bit m_ovf;

   udp_start_seq dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_en       (wr_en),
      .start_valid (start_valid),
      .start_ch    (start_ch),
      .start_ready (start_ready),
      .done_i      (done_i),
      .busy_o      (busy_o),
      .fifo_count  (fifo_count),
      .overflow_o  (overflow_o)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_ch();
      for (int i = 0; i < 4; i++) begin
         if (((m_cur >> i) & 1) != 0) return i;
      end
      return 0;
   endfunction

   function automatic int m_valid();
      return (m_issuing && (((m_busy >> m_ch()) & 1) == 0)) ? 1 : 0;
   endfunction

   task automatic m_reset();
      m_q.delete();
      m_issuing = 1'b0;
      m_cur     = 0;
      m_busy    = 0;
      m_en      = 1'b1;
      m_ovf     = 1'b0;
   endtask

   // One clock edge of the reference: pop/issue decisions use the state before
   // the edge, and fullness uses the queue length before any pop.
   task automatic m_step();
      int size0;
      int ch;
      int hs;
      int bn;
      if (!aresetn) begin
         m_reset();
      end else begin
         size0 = m_q.size();
         ch    = m_ch();
         hs    = (m_valid() != 0 && start_ready) ? 1 : 0;
         bn    = (m_busy & ~int'(done_i)) | ((hs != 0) ? (1 << ch) : 0);
         if (m_issuing) begin
            if (hs != 0) m_cur = m_cur & ~(1 << ch);
            if (m_cur == 0) m_issuing = 1'b0;
         end else if (m_en && size0 > 0) begin
            m_cur     = m_q.pop_front() & 'hF;
            m_issuing = (m_cur != 0);
         end
         if (wr_en && wr_addr == 0) begin
            if (size0 < DEPTH) m_q.push_back(int'(wr_data));
            else m_ovf = 1'b1;
         end
         if (wr_en && wr_addr == 1) begin
            m_en = wr_data[0];
            if (wr_data[1]) m_ovf = 1'b0;
         end
         m_busy = bn;
      end
   endtask

   task automatic cycle();
      @(posedge aclk);
      if (aresetn && start_valid && start_ready) dut_hs++;
      m_step();
      #1;
      wr_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic wr(input int a, input int d);
      wr_addr = 4'(a);
      wr_data = d;
      wr_en   = 1'b1;
      cycle();
   endtask

   always @(negedge aclk) begin
      if (chk_en) begin
         chk("cmp_start_valid", int'(start_valid), m_valid());
         chk("cmp_start_ch", int'(start_ch), m_ch());
         chk("cmp_busy_o", int'(busy_o), m_busy);
         chk("cmp_fifo_count", int'(fifo_count), m_q.size());
         chk("cmp_overflow_o", int'(overflow_o), int'(m_ovf));
      end
   end

   initial begin
      m_reset();
      repeat (2) cycle();
      chk_en = 1'b1;
      chk("rst_valid", int'(start_valid), 0);
      chk("rst_ch", int'(start_ch), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_ovf", int'(overflow_o), 0);
      aresetn     = 1'b1;
      start_ready = 1'b1;
      idle(2);

      // basic issue of mask 0x5
      wr(0, 5);
      chk("basic_count_k1", int'(fifo_count), 1);
      chk("basic_valid_k1", int'(start_valid), 0);
      cycle();
      chk("basic_valid_k2", int'(start_valid), 1);
      chk("basic_ch_k2", int'(start_ch), 0);
      cycle();
      chk("basic_ch_k3", int'(start_ch), 2);
      chk("basic_busy_k3", int'(busy_o), 1);
      cycle();
      chk("basic_valid_k4", int'(start_valid), 0);
      chk("basic_busy_k4", int'(busy_o), 5);
      done_i = 4'h5; cycle(); done_i = '0;
      chk("basic_busy_cleared", int'(busy_o), 0);

      // busy stall keeps order
      wr(0, 2);
      idle(3);
      chk("stall_busy_ch1", int'(busy_o), 2);
      wr(0, 3);
      cycle();
      chk("stall_ch0_valid", int'(start_valid), 1);
      cycle();
      chk("stall_valid_low", int'(start_valid), 0);
      chk("stall_ch1", int'(start_ch), 1);
      idle(3);
      chk("stall_still_low", int'(start_valid), 0);
      done_i = 4'h2; cycle(); done_i = '0;
      chk("stall_release_valid", int'(start_valid), 1);
      chk("stall_release_ch", int'(start_ch), 1);
      cycle();
      chk("stall_busy_both", int'(busy_o), 3);
      done_i = 4'h3; cycle(); done_i = '0;

      // backpressure holds request stable
      start_ready = 1'b0;
      wr(0, 8);
      cycle();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", int'(start_valid), 1);
         chk("bp_ch", int'(start_ch), 3);
         chk("bp_busy", int'(busy_o), 0);
         cycle();
      end
      start_ready = 1'b1;
      cycle();
      chk("bp_busy_after", int'(busy_o), 8);
      chk("bp_valid_after", int'(start_valid), 0);
      done_i = 4'h8; cycle(); done_i = '0;

      // handshake and done together; done on idle channel
      start_ready = 1'b0;
      wr(0, 1);
      cycle();
      chk("same_valid", int'(start_valid), 1);
      start_ready = 1'b1;
      done_i = 4'h1; cycle(); done_i = '0;
      chk("same_busy_set_wins", int'(busy_o), 1);
      done_i = 4'h1; cycle(); done_i = '0;
      chk("same_busy_cleared", int'(busy_o), 0);
      done_i = 4'h4; cycle(); done_i = '0;
      chk("idle_done_busy", int'(busy_o), 0);

      // zero mask and ignored high bits
      wr(0, 0);
      for (int i = 0; i < 4; i++) begin
         chk("zero_mask_valid", int'(start_valid), 0);
         cycle();
      end
      chk("zero_mask_count", int'(fifo_count), 0);
      wr(0, 32'h30);
      for (int i = 0; i < 4; i++) begin
         chk("high_mask_valid", int'(start_valid), 0);
         cycle();
      end
      wr(0, 32'h12);
      cycle();
      chk("high_bits_valid", int'(start_valid), 1);
      chk("high_bits_ch", int'(start_ch), 1);
      cycle();
      chk("high_bits_busy", int'(busy_o), 2);
      done_i = 4'h2; cycle(); done_i = '0;

      // enable cleared mid-mask lets it finish, next mask waits
      start_ready = 1'b0;
      wr(0, 7);
      wr(0, 1);
      wr(1, 0);
      start_ready = 1'b1;
      idle(8);
      chk("en_off_count", int'(fifo_count), 1);
      chk("en_off_valid", int'(start_valid), 0);
      chk("en_off_busy", int'(busy_o), 7);
      done_i = 4'h7; cycle(); done_i = '0;
      wr(1, 1);
      cycle();
      chk("en_on_valid", int'(start_valid), 1);
      chk("en_on_ch", int'(start_ch), 0);
      cycle();
      done_i = 4'h1; cycle(); done_i = '0;

      // overflow and pointer wrap
      wr(1, 0);
      for (int i = 1; i <= 9; i++) wr(0, i);
      chk("ovf_count_full", int'(fifo_count), 8);
      chk("ovf_set", int'(overflow_o), 1);
      done_i  = 4'hF;
      hs_base = dut_hs;
      wr(1, 1);
      idle(40);
      chk("ovf_starts", dut_hs - hs_base, 13);
      chk("ovf_drained", int'(fifo_count), 0);
      chk("ovf_sticky", int'(overflow_o), 1);
      wr(1, 3);
      chk("ovf_cleared", int'(overflow_o), 0);
      wr(1, 0);
      for (int i = 9; i <= 14; i++) wr(0, i);
      chk("wrap_count", int'(fifo_count), 6);
      hs_base = dut_hs;
      wr(1, 1);
      idle(40);
      chk("wrap_starts", dut_hs - hs_base, 15);
      chk("wrap_drained", int'(fifo_count), 0);
      done_i = '0;
      cycle();

      // reset in the middle of ISSUE with queued masks
      wr(0, 3);
      cycle();
      cycle();
      start_ready = 1'b0;
      chk("mid_busy", int'(busy_o), 1);
      chk("mid_ch", int'(start_ch), 1);
      wr(0, 1);
      wr(0, 2);
      wr(0, 4);
      chk("mid_count", int'(fifo_count), 3);
      chk("mid_valid", int'(start_valid), 1);
      #2;
      aresetn = 1'b0;
      m_reset();
      #1;
      chk("arst_valid", int'(start_valid), 0);
      chk("arst_busy", int'(busy_o), 0);
      chk("arst_count", int'(fifo_count), 0);
      chk("arst_ovf", int'(overflow_o), 0);
      idle(2);
      aresetn     = 1'b1;
      start_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("post_rst_valid", int'(start_valid), 0);
      end
      wr(0, 4);
      cycle();
      chk("post_rst_new_valid", int'(start_valid), 1);
      chk("post_rst_new_ch", int'(start_ch), 2);
      cycle();
      done_i = 4'h4; cycle(); done_i = '0;
      idle(3);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
